// File: rtl/tank_pkg.sv
// Shared tank game definitions: button and direction codes, hitbox size, hit-detector states.
package tank_pkg;

    localparam logic [4:0] BTN_DOWN  = 5'b00001;
    localparam logic [4:0] BTN_RIGHT = 5'b00010;
    localparam logic [4:0] BTN_UP    = 5'b00100;
    localparam logic [4:0] BTN_LEFT  = 5'b01000;
    localparam logic [4:0] BTN_FIRE  = 5'b10000;

    localparam logic [1:0] ICON_UP    = 2'd0;
    localparam logic [1:0] ICON_DOWN  = 2'd1;
    localparam logic [1:0] ICON_LEFT  = 2'd2;
    localparam logic [1:0] ICON_RIGHT = 2'd3;

    localparam int TANK_SIZE = 32;

    typedef enum logic [1:0] {
        HIT_IDLE = 2'd0,
        HIT_REQ  = 2'd1,
        HIT_ANIM = 2'd2,
        HIT_WAIT = 2'd3
    } hit_state_e;

endpackage

// File: rtl/tank_hit_detector_if.sv
// Bullet/tank/explosion signal bundle; master = hit detector (handshake initiator), slave = tank side.
interface tank_hit_detector_if;

    logic [9:0] bullet_x;
    logic [8:0] bullet_y;
    logic       bullet_valid;
    logic [9:0] x_tank;
    logic [8:0] y_tank;
    logic       explosion_ack;
    logic       explosion_flag;
    logic       bullet_kill;
    logic       expl_active;
    logic [9:0] expl_x;
    logic [8:0] expl_y;
    logic [7:0] hit_count;

    modport master (
        input  bullet_x, bullet_y, bullet_valid, x_tank, y_tank, explosion_ack,
        output explosion_flag, bullet_kill, expl_active, expl_x, expl_y, hit_count
    );

    modport slave (
        output bullet_x, bullet_y, bullet_valid, x_tank, y_tank, explosion_ack,
        input  explosion_flag, bullet_kill, expl_active, expl_x, expl_y, hit_count
    );

endinterface

// File: rtl/tank_hitbox.sv
// Combinational point-in-box test; widened compare so boxes near the screen edge never wrap.
module tank_hitbox #(
    parameter int SIZE = 32
) (
    input  logic [9:0] px,
    input  logic [8:0] py,
    input  logic [9:0] box_x,
    input  logic [8:0] box_y,
    input  logic       valid,
    output logic       hit
);

    localparam logic [10:0] SPAN_X = 11'(SIZE - 1);
    localparam logic [9:0]  SPAN_Y = 10'(SIZE - 1);

    logic [10:0] px_w, bx_w;
    logic [9:0]  py_w, by_w;
    logic        in_x, in_y;

    assign px_w = {1'b0, px};
    assign bx_w = {1'b0, box_x};
    assign py_w = {1'b0, py};
    assign by_w = {1'b0, box_y};

    assign in_x = (px_w >= bx_w) && (px_w <= bx_w + SPAN_X);
    assign in_y = (py_w >= by_w) && (py_w <= by_w + SPAN_Y);
    assign hit  = valid && in_x && in_y;

endmodule

// File: rtl/tank_hit_detector.sv
// Bullet-vs-tank hit detector driving the explosion flag/ack handshake and display window.
// Optional feature: define HIT_SCORE_EN to enable the saturating hit_count score register.
//   state | meaning
//   IDLE  | armed, testing bullet against hitbox
//   REQ   | explosion_flag raised, waiting for ack or timeout
//   ANIM  | explosion display window running
//   WAIT  | window done, waiting for stale ack to drop before re-arming
module tank_hit_detector
    import tank_pkg::*;
#(
    parameter int TANK_SIZE   = tank_pkg::TANK_SIZE,
    parameter int EXPL_CYCLES = 6250000,
    parameter int ACK_TIMEOUT = 1023
) (
    input logic                 clk25,
    input logic                 reset,
    tank_hit_detector_if.master bus
);

    hit_state_e  state, state_nxt;
    logic        hit, accept;
    logic        tmo_done, expl_done;
    logic [9:0]  tmo_cnt;
    logic [22:0] expl_cnt;
    logic        kill_q;
    logic [9:0]  expl_x_q;
    logic [8:0]  expl_y_q;

    tank_hitbox #(.SIZE(TANK_SIZE)) u_hitbox (
        .px    (bus.bullet_x),
        .py    (bus.bullet_y),
        .box_x (bus.x_tank),
        .box_y (bus.y_tank),
        .valid (bus.bullet_valid),
        .hit   (hit)
    );

    assign tmo_done  = (tmo_cnt == 10'(ACK_TIMEOUT - 1));
    assign expl_done = (expl_cnt == 23'(EXPL_CYCLES - 1));

    always_ff @(posedge clk25) begin
        if (reset) state <= HIT_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            HIT_IDLE: if (hit) begin
                state_nxt = HIT_REQ;
                accept    = 1'b1;
            end
            HIT_REQ:  if (bus.explosion_ack || tmo_done) state_nxt = HIT_ANIM;
            HIT_ANIM: if (expl_done) state_nxt = bus.explosion_ack ? HIT_WAIT : HIT_IDLE;
            HIT_WAIT: if (!bus.explosion_ack) state_nxt = HIT_IDLE;
            default:  state_nxt = HIT_IDLE;
        endcase
    end

    // Counters run only while staying in their state, so every entry starts from zero.
    always_ff @(posedge clk25) begin
        if (reset) begin
            tmo_cnt  <= '0;
            expl_cnt <= '0;
        end else begin
            tmo_cnt  <= (state == HIT_REQ  && state_nxt == HIT_REQ)  ? tmo_cnt + 10'd1  : '0;
            expl_cnt <= (state == HIT_ANIM && state_nxt == HIT_ANIM) ? expl_cnt + 23'd1 : '0;
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            kill_q   <= 1'b0;
            expl_x_q <= '0;
            expl_y_q <= '0;
        end else begin
            kill_q <= accept;
            if (accept) begin
                expl_x_q <= bus.x_tank;
                expl_y_q <= bus.y_tank;
            end
        end
    end

`ifdef HIT_SCORE_EN
    logic [7:0] hit_cnt;

    always_ff @(posedge clk25) begin
        if (reset)                             hit_cnt <= '0;
        else if (accept && hit_cnt != 8'd255)  hit_cnt <= hit_cnt + 8'd1;
    end

    assign bus.hit_count = hit_cnt;
`else
    assign bus.hit_count = 8'd0;
`endif

    assign bus.explosion_flag = (state == HIT_REQ);
    assign bus.expl_active    = (state == HIT_REQ) || (state == HIT_ANIM);
    assign bus.bullet_kill    = kill_q;
    assign bus.expl_x         = expl_x_q;
    assign bus.expl_y         = expl_y_q;

endmodule
